// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared defaults for the width-converting FIFO (fifo_4) and its storage
// (fifo_mem), plus the pointer-width helper used by both.
// Contents:
//   FIFO_IN_W   default write-word width in bits
//   FIFO_RATIO  default number of output lanes per written word
//   FIFO_DEPTH  default word capacity (power of two)
//   ptr_width() address width needed to index a memory of a given depth
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int FIFO_IN_W  = 16;
   localparam int FIFO_RATIO = 2;
   localparam int FIFO_DEPTH = 32;

   // Width of a pointer that wraps naturally over 'depth' entries.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// DEPTH x W storage array: one synchronous write port, one asynchronous
// (combinational) read port. Holds no control state.
// Ports:
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  contents of mem[raddr], combinational
// -----------------------------------------------------------------------------
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int W     = FIFO_IN_W,
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic                        clk,
   input  logic                        we,
   input  logic [ptr_width(DEPTH)-1:0] waddr,
   input  logic [W-1:0]                wdata,
   input  logic [ptr_width(DEPTH)-1:0] raddr,
   output logic [W-1:0]                rdata
);

   logic [W-1:0] mem [DEPTH];

   // NOTE: the array has no reset; contents are only observable after a write,
   // and leaving it unreset lets synthesis map it onto RAM or plain flops.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_4.sv
// -----------------------------------------------------------------------------
// fifo_4
// Show-ahead FIFO that accepts IN_W-bit words and emits them as RATIO lanes of
// OUT_W = IN_W/RATIO bits each. A word is freed once its last lane is read.
// Parameters:
//   IN_W       write word width
//   RATIO      lanes per word (IN_W % RATIO == 0)
//   DEPTH      word capacity (power of two, >= 2)
//   LSB_FIRST  1: least-significant lane emitted first; 0: most-significant
// Ports:
//   clk            in   clock, rising edge
//   rstn           in   synchronous active-low reset (priority over flush)
//   flush          in   synchronous clear of contents
//   data_in        in   write word
//   input_valid    in   writer offers data_in
//   input_enable   out  FIFO can accept a word (not full)
//   data_out       out  current head lane (0 while empty)
//   output_valid   out  data_out holds a valid lane (not empty)
//   output_enable  in   reader consumes the current lane
//   level          out  words held, a partially read word counting as one
// -----------------------------------------------------------------------------
module fifo_4
   import fifo_pkg::*;
#(
   parameter int IN_W      = FIFO_IN_W,
   parameter int RATIO     = FIFO_RATIO,
   parameter int DEPTH     = FIFO_DEPTH,
   parameter int LSB_FIRST = 1
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     flush,
   input  logic [IN_W-1:0]          data_in,
   input  logic                     input_valid,
   output logic                     input_enable,
   output logic [IN_W/RATIO-1:0]    data_out,
   output logic                     output_valid,
   input  logic                     output_enable,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int OUT_W  = IN_W / RATIO;
   localparam int PTR_W  = ptr_width(DEPTH);
   localparam int LVL_W  = $clog2(DEPTH) + 1;
   localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
   localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LANE_W-1:0] lane_idx;
   logic [LVL_W-1:0]  level_q;
   logic [IN_W-1:0]   head_word;

   logic full;
   logic empty;
   logic wr_en;
   logic rd_en;
   logic rd_done;

   // Status comes from the registered level only, so the handshake outputs
   // never depend combinationally on input_valid or output_enable.
   assign full         = (level_q == FULL_LVL);
   assign empty        = (level_q == '0);
   assign input_enable = !full;
   assign output_valid = !empty;
   assign level        = level_q;

   assign wr_en   = input_valid && !full;
   assign rd_en   = output_enable && !empty;
   assign rd_done = rd_en && (lane_idx == LAST_LANE);

   fifo_mem #(
      .W     (IN_W),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_en && rstn && !flush),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (head_word)
   );

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         lane_idx <= '0;
         level_q  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            if (rd_done) begin
               lane_idx <= '0;
               rd_ptr   <= rd_ptr + 1'b1;
            end else begin
               lane_idx <= lane_idx + 1'b1;
            end
         end
         // Level moves only on whole words: a non-final lane read frees nothing.
         unique case ({wr_en, rd_done})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // Map the read order onto physical lane position within the head word.
   logic [LANE_W-1:0] sel;
   logic [OUT_W-1:0]  lane_data;

   // NOTE: every output of this block gets a default first so no path through
   // the loop can leave it unassigned and infer a latch.
   always_comb begin
      sel       = (LSB_FIRST != 0) ? lane_idx : (LAST_LANE - lane_idx);
      lane_data = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (sel == LANE_W'(i)) begin
            lane_data = head_word[i*OUT_W +: OUT_W];
         end
      end
   end

   assign data_out = empty ? '0 : lane_data;

endmodule

// File: tb/tb_fifo_4.sv
// -----------------------------------------------------------------------------
// tb_fifo_4
// Self-checking bench for fifo_4. Instance u_dut (16-bit words, 2 lanes,
// depth 4, LSB first) is compared against a lane-queue reference model; an
// instance u_dut_b (32-bit words, 4 lanes, MSB first) checks lane ordering.
// -----------------------------------------------------------------------------
module tb_fifo_4;

   localparam int IN_W  = 16;
   localparam int RATIO = 2;
   localparam int DEPTH = 4;
   localparam int OUT_W = IN_W / RATIO;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rstn;
   logic             flush;
   logic [IN_W-1:0]  data_in;
   logic             input_valid;
   logic             input_enable;
   logic [OUT_W-1:0] data_out;
   logic             output_valid;
   logic             output_enable;
   logic [2:0]       level;

   logic        flush_b;
   logic [31:0] data_in_b;
   logic        input_valid_b;
   logic        input_enable_b;
   logic [7:0]  data_out_b;
   logic        output_valid_b;
   logic        output_enable_b;
   logic [2:0]  level_b;

   fifo_4 #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH), .LSB_FIRST(1)) u_dut (
      .clk           (clk),
      .rstn          (rstn),
      .flush         (flush),
      .data_in       (data_in),
      .input_valid   (input_valid),
      .input_enable  (input_enable),
      .data_out      (data_out),
      .output_valid  (output_valid),
      .output_enable (output_enable),
      .level         (level)
   );

   fifo_4 #(.IN_W(32), .RATIO(4), .DEPTH(4), .LSB_FIRST(0)) u_dut_b (
      .clk           (clk),
      .rstn          (rstn),
      .flush         (flush_b),
      .data_in       (data_in_b),
      .input_valid   (input_valid_b),
      .input_enable  (input_enable_b),
      .data_out      (data_out_b),
      .output_valid  (output_valid_b),
      .output_enable (output_enable_b),
      .level         (level_b)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: the FIFO is a queue of lanes in emission order. A word
   // is pushed as RATIO lanes; the number of words held is the lane count
   // rounded up to whole words.
   // ---------------------------------------------------------------------------
   logic [OUT_W-1:0] exp_q[$];
   bit               armed = 1'b0;

   function automatic int words_held();
      return (exp_q.size() + RATIO - 1) / RATIO;
   endfunction

   function automatic logic [OUT_W-1:0] lane_of(input logic [IN_W-1:0] w, input int k);
      logic [IN_W-1:0] s;
      s = w >> (k * OUT_W);
      return s[OUT_W-1:0];
   endfunction

   initial begin : model
      forever begin
         @(posedge clk);
         if (!rstn || flush) begin
            exp_q.delete();
            if (!rstn) armed = 1'b1;
         end else begin
            bit wr;
            bit rd;
            wr = input_valid && (words_held() < DEPTH);
            rd = output_enable && (exp_q.size() > 0);
            if (rd) void'(exp_q.pop_front());
            if (wr) begin
               for (int k = 0; k < RATIO; k++) exp_q.push_back(lane_of(data_in, k));
            end
         end
      end
   end

   // Monitor: away from the active edge, compare everything the DUT presents
   // against the model's current view.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (armed) begin
            check("output_valid", 32'(output_valid), 32'(exp_q.size() > 0));
            check("input_enable", 32'(input_enable), 32'(words_held() < DEPTH));
            check("level", 32'(level), 32'(words_held()));
            check("data_out", 32'(data_out), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
         end
      end
   end

   // Second instance: expected lanes queued when a write is issued, popped by
   // the monitor whenever the DUT offers a lane that is being consumed.
   logic [7:0] qb[$];

   initial begin : monitor_b
      forever begin
         @(negedge clk);
         if (armed && output_valid_b && output_enable_b) begin
            if (qb.size() == 0) check("b_unexpected_lane", 32'(output_valid_b), 32'd0);
            else                check("b_data_out", 32'(data_out_b), 32'(qb.pop_front()));
         end
      end
   end

   task automatic cyc(input logic iv, input logic [IN_W-1:0] d, input logic oe, input logic fl);
      @(posedge clk);
      #1;
      input_valid   = iv;
      data_in       = d;
      output_enable = oe;
      flush         = fl;
   endtask

   initial begin : stimulus
      rstn            = 1'b0;
      flush           = 1'b0;
      data_in         = '0;
      input_valid     = 1'b0;
      output_enable   = 1'b1;
      flush_b         = 1'b0;
      data_in_b       = '0;
      input_valid_b   = 1'b0;
      output_enable_b = 1'b1;

      // Reset with output_enable held high.
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      cyc(0, 16'h0, 0, 0);

      // Single word, two lanes: B2 then A1.
      cyc(1, 16'hA1B2, 0, 0);
      cyc(0, 16'h0, 1, 0);
      cyc(0, 16'h0, 1, 0);
      cyc(0, 16'h0, 0, 0);

      // Overfill by one, then drain through the pointer wrap.
      for (int i = 1; i <= 5; i++) cyc(1, IN_W'(i), 0, 0);
      for (int i = 0; i < 8; i++)  cyc(0, 16'h0, 1, 0);
      cyc(0, 16'h0, 0, 0);

      // Full: write together with a word-completing read is refused.
      for (int i = 0; i < 4; i++) cyc(1, 16'h1100 + IN_W'(i), 0, 0);
      cyc(0, 16'h0, 1, 0);
      cyc(1, 16'hAAAA, 1, 0);
      cyc(1, 16'hBBBB, 0, 0);
      for (int i = 0; i < 8; i++) cyc(0, 16'h0, 1, 0);
      cyc(0, 16'h0, 0, 0);

      // Flush beats a simultaneous write and read.
      cyc(1, 16'h1234, 0, 0);
      cyc(0, 16'h0, 1, 0);
      cyc(1, 16'hCCCC, 1, 1);
      cyc(1, 16'h5678, 0, 0);
      cyc(0, 16'h0, 1, 0);
      cyc(0, 16'h0, 1, 0);
      cyc(0, 16'h0, 0, 0);

      // Reset mid-word discards the partial word.
      cyc(1, 16'h9ABC, 0, 0);
      cyc(0, 16'h0, 1, 0);
      cyc(0, 16'h0, 0, 0);
      rstn = 1'b0;
      cyc(0, 16'h0, 0, 0);
      rstn = 1'b1;
      cyc(1, 16'h4321, 0, 0);
      cyc(0, 16'h0, 1, 0);
      cyc(0, 16'h0, 1, 0);

      // Randomised traffic with occasional flush and reset.
      for (int i = 0; i < 600; i++) begin
         @(posedge clk);
         #1;
         input_valid   = 1'($urandom_range(0, 1));
         output_enable = ($urandom_range(0, 3) != 0);
         data_in       = IN_W'($urandom);
         flush         = ($urandom_range(0, 40) == 0);
         rstn          = ($urandom_range(0, 80) != 0);
      end
      cyc(0, 16'h0, 1, 0);
      rstn = 1'b1;
      for (int i = 0; i < 10; i++) cyc(0, 16'h0, 1, 0);

      // MSB-first, four lanes.
      @(posedge clk);
      #1;
      output_enable_b = 1'b0;
      input_valid_b   = 1'b1;
      data_in_b       = 32'hDEADBEEF;
      qb.push_back(8'hDE);
      qb.push_back(8'hAD);
      qb.push_back(8'hBE);
      qb.push_back(8'hEF);
      @(posedge clk);
      #1;
      input_valid_b   = 1'b0;
      output_enable_b = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("b_drained", 32'(qb.size()), 32'd0);
      check("b_output_valid_after", 32'(output_valid_b), 32'd0);
      check("b_level_after", 32'(level_b), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
